// File: rtl/icache_types.sv
// Shared types and geometry for the 2-way set-associative instruction cache.
//   S_OFFSET   : log2 of line size in bytes (32 B line, 8 words)
//   S_INDEX    : log2 of number of sets (8 sets)
//   TAG_W      : address bits above index and offset
//   INDEX_W    : set-select width
//   WORD_SEL_W : word-within-line select width
//   LINE_W     : line width in bits (256)
package icache_types;

  localparam int S_OFFSET   = 5;
  localparam int S_INDEX    = 3;
  localparam int TAG_W      = 32 - S_OFFSET - S_INDEX;
  localparam int INDEX_W    = S_INDEX;
  localparam int WORD_SEL_W = S_OFFSET - 2;
  localparam int NUM_SETS   = 1 << S_INDEX;
  localparam int LINE_W     = 8 << S_OFFSET;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: per-set valid bit, tag and line storage.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears valid bits only)
//   rd_index   : set selected by the current fetch address (combinational read)
//   rd_valid/rd_tag/rd_line : contents of the rd_index set
//   wr_index   : set being refilled
//   wr_valid   : valid bit of the wr_index set (used for victim choice)
//   load       : write wr_tag/wr_line into wr_index and mark it valid
module icache_way
  import icache_types::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic               load,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_line,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_line,
  output logic               wr_valid
);

  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]    tag_arr  [NUM_SETS];
  logic [LINE_W-1:0]   line_arr [NUM_SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (load) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (load) begin
      tag_arr[wr_index]  <= wr_tag;
      line_arr[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_arr[rd_index];
  assign rd_line  = line_arr[rd_index];
  assign wr_valid = valid[wr_index];

endmodule

// File: rtl/instruction_cache.sv
// Read-only 2-way set-associative instruction cache.
// Hits respond combinationally in the request cycle; misses fetch a full
// 256-bit line over the pmem_read/pmem_resp handshake and then hit.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   inst_read     : fetch request (may be held high)
//   inst_addr     : fetch byte address ([1:0] ignored)
//   inst_resp     : inst_rdata valid, request complete
//   inst_rdata    : instruction word (0 when inst_resp is low)
//   pmem_read     : line read request, high for the whole fill
//   pmem_address  : line-aligned miss address
//   pmem_rdata    : returned line, word w at bits [32w+31:32w]
//   pmem_resp     : one-cycle pulse marking pmem_rdata valid
module instruction_cache
  import icache_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_read,
  input  logic [31:0]       inst_addr,
  output logic              inst_resp,
  output logic [31:0]       inst_rdata,
  output logic              pmem_read,
  output logic [31:0]       pmem_address,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  icache_state_t       state;
  logic [31:0]         miss_addr;
  logic [NUM_SETS-1:0] lru;

  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    req_index;
  logic [WORD_SEL_W-1:0] req_word;
  logic [TAG_W-1:0]      miss_tag;
  logic [INDEX_W-1:0]    miss_index;

  logic [1:0]        rd_valid;
  logic [1:0]        wr_valid;
  logic [TAG_W-1:0]  rd_tag  [2];
  logic [LINE_W-1:0] rd_line [2];
  logic [1:0]        hit_way;
  logic [1:0]        load;

  logic              lookup;
  logic              hit;
  logic              miss;
  logic              fill;
  logic              hit_sel;
  logic              victim;
  logic [LINE_W-1:0] sel_line;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^inst_addr[1:0];

  assign req_tag    = inst_addr[31 -: TAG_W];
  assign req_index  = inst_addr[S_OFFSET +: INDEX_W];
  assign req_word   = inst_addr[2 +: WORD_SEL_W];
  assign miss_tag   = miss_addr[31 -: TAG_W];
  assign miss_index = miss_addr[S_OFFSET +: INDEX_W];

  for (genvar w = 0; w < 2; w++) begin : g_way
    icache_way u_way (
      .clk      (clk),
      .rst      (rst),
      .rd_index (req_index),
      .wr_index (miss_index),
      .load     (load[w]),
      .wr_tag   (miss_tag),
      .wr_line  (pmem_rdata),
      .rd_valid (rd_valid[w]),
      .rd_tag   (rd_tag[w]),
      .rd_line  (rd_line[w]),
      .wr_valid (wr_valid[w])
    );
    assign hit_way[w] = rd_valid[w] & (rd_tag[w] == req_tag);
    // A fill racing a reset is dropped so no stale line becomes valid.
    assign load[w]    = fill & (victim == 1'(w)) & ~rst;
  end

  // Lookups happen only in IDLE: no hit-under-miss while a fill is in flight.
  assign lookup  = (state == IDLE) & inst_read;
  assign hit     = lookup & (|hit_way);
  assign miss    = lookup & ~(|hit_way);
  assign fill    = (state == FETCH) & pmem_resp;
  assign hit_sel = hit_way[1];

  // Prefer an empty way; only a full set consults lru.
  assign victim = ~wr_valid[0] ? 1'b0 :
                  ~wr_valid[1] ? 1'b1 : lru[miss_index];

  assign sel_line     = rd_line[hit_sel];
  assign inst_resp    = hit;
  assign inst_rdata   = hit ? sel_line[{req_word, 5'b0} +: 32] : 32'h0;
  assign pmem_read    = (state == FETCH);
  assign pmem_address = miss_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lru   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            lru[req_index] <= ~hit_sel;
          end
          if (miss) begin
            miss_addr <= {req_tag, req_index, {S_OFFSET{1'b0}}};
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (pmem_resp) begin
            lru[miss_index] <= ~victim;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
